// File: rtl/multicycle_mainfsm.sv
// Main control FSM of the multicycle RV32I core: steps each instruction through
// fetch/decode/execute/memory/writeback and decodes datapath controls from the state.
module multicycle_mainfsm #(
  parameter int MEM_HANDSHAKE = 0,
  parameter int EN_JALR       = 1,
  parameter int EN_UPPER      = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_JALR_ADR = 4'd11,
    S_JALR_PC  = 4'd12,
    S_UPPER    = 4'd13,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_t r_state;
  state_t w_next;
  logic   w_rdy;

  // Raw strobes before reset gating
  logic w_pcu;
  logic w_br;
  logic w_rw;
  logic w_mw;
  logic w_irw;
  logic w_ret;
  logic w_ill;

  assign w_rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (w_rdy) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:     w_next = S_MEMADR;
          OP_R:             w_next = S_EXECR;
          OP_IALU:          w_next = S_EXECI;
          OP_BR:            w_next = S_BEQ;
          OP_JAL:           w_next = S_JAL;
          OP_JALR:          w_next = (EN_JALR != 0) ? S_JALR_ADR : S_TRAP;
          OP_LUI, OP_AUIPC: w_next = (EN_UPPER != 0) ? S_UPPER : S_TRAP;
          default:          w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (w_rdy) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (w_rdy) w_next = S_FETCH;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_JALR_ADR: w_next = S_JALR_PC;
      S_JALR_PC:  w_next = S_ALUWB;
      S_UPPER:    w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pcu     = 1'b0;
    w_br      = 1'b0;
    w_rw      = 1'b0;
    w_mw      = 1'b0;
    w_irw     = 1'b0;
    w_ret     = 1'b0;
    w_ill     = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irw     = w_rdy;
        w_pcu     = w_rdy;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_rw      = 1'b1;
        w_ret     = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        w_mw   = 1'b1;
        w_ret  = w_rdy;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        w_rw  = 1'b1;
        w_ret = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        w_br    = 1'b1;
        w_ret   = 1'b1;
      end
      S_JAL, S_JALR_PC: begin
        // Return address PC+4 is computed from OldPC while PC takes the target
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        w_pcu   = 1'b1;
      end
      S_JALR_ADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_UPPER: begin
        ALUSrcA = (op == OP_LUI) ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
      end
      S_TRAP: begin
        w_ill = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:            ImmSrc = 3'b001;
      OP_BR:            ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
  end

  // Strobes are held off for the whole reset cycle so an abandoned instruction writes nothing
  assign PCUpdate  = reset_n & w_pcu;
  assign Branch    = reset_n & w_br;
  assign RegWrite  = reset_n & w_rw;
  assign MemWrite  = reset_n & w_mw;
  assign IRWrite   = reset_n & w_irw;
  assign retire    = reset_n & w_ret;
  assign illegal   = reset_n & w_ill;
  assign state_dbg = r_state;

endmodule

// File: doc/multicycle_mainfsm.md
Name: multicycle_mainfsm

Overview:
Main control FSM for the multicycle RV32I core; it replaces the single-cycle main decoder when the core moves to a shared instruction/data memory.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives datapath enables and muxes from a registered state.
- Optionally stalls on a memory-ready handshake, and supports jalr/lui/auipc.
- Traps on illegal opcodes.

Parameters:
MEM_HANDSHAKE, 0, 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0 = mem_ready ignored, treated as 1
EN_JALR, 1, 1 = jalr (1100111) legal; 0 = treated as illegal
EN_UPPER, 1, 1 = lui (0110111) and auipc (0010111) legal; 0 = treated as illegal

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  synchronous, active-low reset
op  in  7  opcode field of the instruction register
mem_ready  in  1  memory completes the current access this cycle
PCUpdate  out  1  PC write enable
Branch  out  1  conditional PC write (datapath ANDs with Zero)
RegWrite  out  1  register file write enable
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register / OldPC load
AdrSrc  out  1  memory address: 0 = PC, 1 = Result
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1, 11 = zero
ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
ALUOp  out  2  00 = add, 01 = sub/branch, 10 = funct-decoded
ImmSrc  out  3  combinational from op: I 000, S 001, B 010, J 011, U 100; others 000
retire  out  1  1-cycle pulse in the final state of each instruction
illegal  out  1  high while in TRAP
state_dbg  out  4  current state encoding

Behaviour:
- State register reset: on a clk edge with reset_n = 0, state <= FETCH. While reset_n = 0, force PCUpdate, Branch, RegWrite, MemWrite, IRWrite, retire and illegal to 0. Reset asserted mid-instruction abandons that instruction; no partial writes occur after the reset edge.
- Outputs are Moore (decoded from state), except ImmSrc (from op) and the mem_ready qualification below. Unlisted outputs are 0 in every state.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, JALR_ADR 11, JALR_PC 12, UPPER 13, TRAP 15.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite = PCUpdate = rdy, where rdy = mem_ready if MEM_HANDSHAKE, else 1. Go to DECODE when rdy, else stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
  - lw/sw -> MEMADR
  - R-type -> EXECR
  - I-ALU -> EXECI
  - branch -> BEQ
  - jal -> JAL
  - jalr -> JALR_ADR if EN_JALR
  - lui/auipc -> UPPER if EN_UPPER
  - anything else -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op = lw, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Go to MEMWB on rdy, else stay.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held every cycle until rdy. retire=rdy. Go to FETCH on rdy.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1. Next: FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, retire=1. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- JALR_ADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: JALR_PC. Target LSB clearing is done by the datapath.
- JALR_PC: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- UPPER: ALUSrcB=01, ALUOp=00. ALUSrcA=11 for lui, 01 for auipc. Next: ALUWB.
- TRAP: illegal=1, all strobes 0. Stays until reset.
- CPI with rdy always 1:
  - lw 5
  - sw 4
  - R/I/lui/auipc 4
  - branch 3
  - jal 4
  - jalr 5
- Each wait cycle adds 1. op is only sampled in DECODE and MEMADR and in UPPER's ALUSrcA mux; it is held stable by IR outside FETCH.

Test Plan:
- Reset then lw (op 0000011), mem_ready = 1 -> states 0,1,2,3,4,0; RegWrite only in state 4; retire pulses once; ImmSrc = 000.
- MEM_HANDSHAKE = 1, sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite high 4 consecutive cycles; retire only on the ready cycle; then FETCH.
- FETCH with mem_ready low 2 cycles -> IRWrite/PCUpdate stay 0 for those cycles, then pulse 1 cycle; state 1 follows.
- jalr with EN_JALR = 1 -> states 0,1,11,12,8; PCUpdate in state 12. Same op with EN_JALR = 0 -> state 15, illegal = 1, stays until reset_n low.
- lui -> UPPER with ALUSrcA = 11, ImmSrc = 100. auipc -> ALUSrcA = 01. Both followed by ALUWB with RegWrite = 1.
- reset_n low during MEMREAD wait -> all strobes 0 that cycle; next state FETCH; no RegWrite for the aborted lw.
